// File: rtl/al_clkdiv_seq_ctrl.sv
// al_clkdiv_seq_ctrl: IO clock leg sequencer (stop -> reset -> hold -> release -> resume).
// Optional PLL lock supervision is enabled by defining AL_CLKSEQ_LOCK_EN.
module al_clkdiv_seq_ctrl #(
  parameter int STOP_CYC = 4,
  parameter int RST_CYC  = 8,
  parameter int RLS_CYC  = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clki,
  input  logic       rst,
`ifdef AL_CLKSEQ_LOCK_EN
  input  logic       pll_lock,
`endif
  input  logic       req,
  output logic       busy,
  output logic       done,
  output logic       ioclk_stop,
  output logic       div_rst,
  output logic       div_rls,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STOP  = 3'd1,
    S_RESET = 3'd2,
    S_HOLD  = 3'd3,
    S_RLS   = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] D_STOP = (STOP_CYC <= 1) ? '0 : CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] D_RST  = (RST_CYC  <= 1) ? '0 : CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] D_RLS  = (RLS_CYC  <= 1) ? '0 : CNT_W'(RLS_CYC - 1);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_dwell;
  logic             r_pend, r_fresh, w_pend_nxt, w_req, w_lock, w_last, w_enter;
`ifdef AL_CLKSEQ_LOCK_EN
  logic [1:0] r_sync;
  logic       r_lock_d;
  always_ff @(posedge clki) begin
    if (rst) begin
      r_sync   <= '0;
      r_lock_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], pll_lock};
      r_lock_d <= r_sync[1];
    end
  end
  assign w_lock = r_sync[1];
  assign w_req  = req | (r_state == S_IDLE && r_lock_d && !w_lock);
`else
  assign w_lock = 1'b1;
  assign w_req  = req;
`endif
  // r_fresh marks the STOP state left by reset: its dwell starts on the first edge out of reset
  assign w_last  = r_cnt == '0 && !r_fresh;
  assign w_enter = w_nxt != r_state;
  assign w_dwell = (w_nxt == S_STOP || w_nxt == S_RLS) ? D_STOP :
                   (w_nxt == S_RESET) ? D_RST :
                   (w_nxt == S_HOLD)  ? D_RLS : '0;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = r_pend ? S_STOP : S_IDLE;
      S_STOP:  w_nxt = (w_last && w_lock) ? S_RESET : S_STOP;
      S_RESET: w_nxt = w_last ? S_HOLD : S_RESET;
      S_HOLD:  w_nxt = w_last ? S_RLS : S_HOLD;
      S_RLS:   w_nxt = w_last ? S_IDLE : S_RLS;
      default: w_nxt = S_STOP;
    endcase
    if (!w_lock && r_state != S_IDLE && r_state != S_STOP) w_nxt = S_STOP;
  end
  assign w_cnt_nxt  = w_enter ? w_dwell :
                      r_fresh ? D_STOP :
                      (r_cnt != '0) ? r_cnt - 1'b1 : '0;
  assign w_pend_nxt = (w_enter && w_nxt == S_STOP) ? 1'b0 : (r_pend | w_req);
  always_ff @(posedge clki) begin
    if (rst) begin
      r_state    <= S_STOP;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_fresh    <= 1'b1;
      ioclk_stop <= 1'b1;
      div_rst    <= 1'b0;
      div_rls    <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_fresh    <= 1'b0;
      ioclk_stop <= w_nxt != S_IDLE;
      div_rst    <= w_nxt == S_RESET;
      div_rls    <= w_nxt == S_IDLE || w_nxt == S_RLS;
      busy       <= w_nxt != S_IDLE;
      done       <= w_nxt == S_IDLE && r_state == S_RLS;
    end
  end
  assign state_o = r_state;
endmodule

// File: tb/tb_al_clkdiv_seq_ctrl.sv
// tb_al_clkdiv_seq_ctrl: random req/rst stimulus on two configurations (4/8/4 and 1/1/1)
// checked every cycle against a sequence-position reference model.
module tb_al_clkdiv_seq_ctrl;
  logic       clki = 1'b0;
  logic       rst, req;
  logic       busy[2], done[2], ioclk_stop[2], div_rst[2], div_rls[2];
  logic [2:0] state_o[2];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clki = ~clki;
  al_clkdiv_seq_ctrl u_dut0 (
    .clki(clki), .rst(rst),
`ifdef AL_CLKSEQ_LOCK_EN
    .pll_lock(1'b1),
`endif
    .req(req), .busy(busy[0]), .done(done[0]), .ioclk_stop(ioclk_stop[0]),
    .div_rst(div_rst[0]), .div_rls(div_rls[0]), .state_o(state_o[0])
  );
  al_clkdiv_seq_ctrl #(.STOP_CYC(1), .RST_CYC(1), .RLS_CYC(1)) u_dut1 (
    .clki(clki), .rst(rst),
`ifdef AL_CLKSEQ_LOCK_EN
    .pll_lock(1'b1),
`endif
    .req(req), .busy(busy[1]), .done(done[1]), .ioclk_stop(ioclk_stop[1]),
    .div_rst(div_rst[1]), .div_rls(div_rls[1]), .state_o(state_o[1])
  );
  // model: sequence position in cycles since STOP entry, or idle
  int s_cyc[2] = '{4, 1};
  int r_cyc[2] = '{8, 1};
  int l_cyc[2] = '{4, 1};
  int m_pos[2];
  bit m_idle[2], m_held[2], m_pend[2], m_done[2];
  initial for (int k = 0; k < 2; k++) begin
    m_pos[k] = 0; m_idle[k] = 0; m_held[k] = 1; m_pend[k] = 0; m_done[k] = 0;
  end
  always @(posedge clki) begin
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (rst) begin
        m_held[k] = 1; m_idle[k] = 0; m_pos[k] = 0; m_pend[k] = 0;
      end else if (m_held[k]) begin
        m_held[k] = 0; m_pos[k] = 0; m_pend[k] = m_pend[k] | req;
      end else if (m_idle[k]) begin
        if (m_pend[k]) begin
          m_idle[k] = 0; m_pos[k] = 0; m_pend[k] = 0;
        end else m_pend[k] = req;
      end else begin
        m_pos[k]++;
        m_pend[k] = m_pend[k] | req;
        if (m_pos[k] == 2 * s_cyc[k] + r_cyc[k] + l_cyc[k]) begin
          m_idle[k] = 1; m_done[k] = 1;
        end
      end
    end
  end
  function automatic logic [7:0] expect_vec(int k);
    int p = m_pos[k];
    logic [2:0] st;
    if (m_idle[k]) return {3'd0, 1'b0, m_done[k], 1'b0, 1'b0, 1'b1};
    st = (p < s_cyc[k]) ? 3'd1 : (p < s_cyc[k] + r_cyc[k]) ? 3'd2 :
         (p < s_cyc[k] + r_cyc[k] + l_cyc[k]) ? 3'd3 : 3'd4;
    return {st, 1'b1, 1'b0, 1'b1, st == 3'd2, st == 3'd4};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [1:0] done_prev = '0;
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "outs_cfg484" : "outs_cfg111",
          {24'd0, state_o[k], busy[k], done[k], ioclk_stop[k], div_rst[k], div_rls[k]},
          {24'd0, expect_vec(k)});
      chk(k == 0 ? "inv_cfg484" : "inv_cfg111",
          {29'd0, div_rst[k] & ~ioclk_stop[k], div_rst[k] & div_rls[k], done[k] & done_prev[k]},
          32'd0);
      done_prev[k] = done[k];
    end
  endtask
  initial begin
    rst = 1'b1; req = 1'b0;
    repeat (3) @(negedge clki);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clki); check_all();
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clki);
      check_all();
      req = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 4 : 25));
      rst = ($urandom_range(0, 249) == 0);
    end
    rst = 1'b0; req = 1'b0;
    repeat (30) begin
      @(negedge clki); check_all();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
